// File: rtl/rv32i_rf_pkg.sv
// Shared sizing helpers, register-address type and x0 constant for the RV32I register file.
package rv32i_rf_pkg;

  // Address width for a register count (at least one bit).
  function automatic int unsigned calc_aw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to count 0..n inclusive.
  function automatic int unsigned calc_cw(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned RV_NUM_REGS = 32;

  typedef logic [calc_aw(RV_NUM_REGS)-1:0] reg_addr_t;

  localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/rv32i_rf_scoreboard.sv
// Write-back scoreboard: one pending bit per architectural register plus a registered
// population count. Update order per edge is flush, then completing writes, then reservation.
module rv32i_rf_scoreboard
  import rv32i_rf_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned NUM_WR_PORTS = 1,
  localparam int unsigned AW          = calc_aw(NUM_REGS),
  localparam int unsigned CW          = calc_cw(NUM_REGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WR_PORTS-1:0]          wr_en_i,
  input  logic [NUM_WR_PORTS-1:0][AW-1:0]  wr_addr_i,
  input  logic                             rsv_en_i,
  input  logic [AW-1:0]                    rsv_addr_i,
  input  logic                             flush_i,
  output logic [NUM_REGS-1:0]              pending_o,
  output logic [CW-1:0]                    pending_cnt_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // Next pending vector; later steps override earlier ones so a new reservation
  // supersedes a completing write to the same register.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end
    for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w] != AW'(X0))) begin
        pending_d[wr_addr_i[w]] = 1'b0;
      end
    end
    if (rsv_en_i && (rsv_addr_i != AW'(X0))) begin
      pending_d[rsv_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Population count of the next vector so the count tracks the bits on the same edge.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + CW'(pending_d[i]);
    end
  end

  // Pending bits and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_o     = pending_q;
  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/rv32i_regfile_sb.sv
// Multi-port RV32I integer register file with asynchronous reads, optional write-to-read
// bypass, synchronous writes (highest port wins) and an integrated write-back scoreboard.
module rv32i_regfile_sb
  import rv32i_rf_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_WR_PORTS = 1,
  parameter bit          BYPASS       = 1'b1,
  localparam int unsigned AW          = calc_aw(NUM_REGS),
  localparam int unsigned CW          = calc_cw(NUM_REGS)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0]          rd_addr,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_RD_PORTS-1:0]                  rd_busy,
  input  logic [NUM_WR_PORTS-1:0]                  wr_en,
  input  logic [NUM_WR_PORTS-1:0][AW-1:0]          wr_addr,
  input  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0]  wr_data,
  input  logic                                     rsv_en,
  input  logic [AW-1:0]                            rsv_addr,
  input  logic                                     flush,
  output logic [CW-1:0]                            pending_cnt
);

  logic [DATA_WIDTH-1:0]                   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]                   regs_d [NUM_REGS];
  logic [NUM_WR_PORTS-1:0]                 wr_act;
  logic [NUM_WR_PORTS-1:0][NUM_REGS-1:0]   wr_hit;
  logic [NUM_REGS-1:0]                     pending;

  // Write-port decode: one-hot target per port, x0 writes never hit.
  for (genvar w = 0; w < NUM_WR_PORTS; w++) begin : g_wr
    assign wr_act[w] = wr_en[w] && (wr_addr[w] != AW'(X0));
    assign wr_hit[w] = wr_act[w] ? (NUM_REGS'(1) << wr_addr[w]) : '0;
  end

  // Next storage contents; higher-index ports are applied last and therefore win.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_hit[w][i]) begin
          regs_d[i] = wr_data[w];
        end
      end
    end
    regs_d[0] = '0;
  end

  // Register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  rv32i_rf_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_WR_PORTS (NUM_WR_PORTS)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .rsv_en_i      (rsv_en),
    .rsv_addr_i    (rsv_addr),
    .flush_i       (flush),
    .pending_o     (pending),
    .pending_cnt_o (pending_cnt)
  );

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_bsy;

    // Read mux: stored value, overridden by an in-flight write (highest port wins), x0 forced to 0.
    always_comb begin
      rd_val = regs_q[rd_addr[p]];
      rd_bsy = pending[rd_addr[p]];
      if (BYPASS) begin
        for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
          if (wr_act[w] && (wr_addr[w] == rd_addr[p])) begin
            rd_val = wr_data[w];
            rd_bsy = 1'b0;
          end
        end
      end
      if (rd_addr[p] == AW'(X0)) begin
        rd_val = '0;
        rd_bsy = 1'b0;
      end
    end

    assign rd_data[p] = rd_val;
    assign rd_busy[p] = rd_bsy;
  end

endmodule

// File: doc/rv32i_regfile_sb.md
# rv32i_regfile_sb

Parametrised multi-port RV32I integer register file with an integrated write-back scoreboard, for the pipelined core that replaces the single-cycle datapath. It provides N asynchronous read ports with optional same-cycle write-to-read bypass and M synchronous write ports. It tracks which architectural registers have an in-flight producer, so the issue stage can stall on RAW hazards. x0 is hardwired to zero and is never reserved.

## Interface
- NUM_REGS, 32: architectural register count; must be a power of two.
- DATA_WIDTH, 32: register width.
- NUM_RD_PORTS, 2: read port count, 1 to 4.
- NUM_WR_PORTS, 1: write port count, 1 to 2.
- BYPASS, 1: 1 makes a same-cycle write visible on read ports; 0 returns stored data only.

Ports (AW = $clog2(NUM_REGS), CW = $clog2(NUM_REGS+1)):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  [NUM_RD_PORTS][AW]  read addresses
- rd_data  out  [NUM_RD_PORTS][DATA_WIDTH]  read data
- rd_busy  out  [NUM_RD_PORTS]  addressed register has an outstanding producer
- wr_en  in  [NUM_WR_PORTS]  write strobes
- wr_addr  in  [NUM_WR_PORTS][AW]  write addresses
- wr_data  in  [NUM_WR_PORTS][DATA_WIDTH]  write data
- rsv_en  in  1  reserve a destination at issue
- rsv_addr  in  AW  destination to reserve
- flush  in  1  drop all reservations (pipeline flush)
- pending_cnt  out  CW  number of reserved registers

## Operation
- Storage: NUM_REGS × DATA_WIDTH flops. Entry 0 exists but is never written and always reads 0.
- Reads are combinational:
  - rd_addr==0 gives 0.
  - Otherwise, if BYPASS and a write port has wr_en with wr_addr==rd_addr this cycle, the read returns that port's wr_data. If several ports match, the highest index wins.
  - Otherwise the read returns the stored value.
- Writes occur on posedge clk when wr_en is set and wr_addr!=0. If several ports hit the same address, the highest index wins. Writes to x0 are dropped.
- Scoreboard: one pending bit per register. Bit 0 is constant 0. On each clock edge, bits update in this order:
  1. flush clears all bits.
  2. Each wr_en with wr_addr!=0 clears its bit.
  3. rsv_en with rsv_addr!=0 sets its bit.
- Consequences of that order:
  - Reserve and write to the same register in one cycle leaves the bit set, because the new producer supersedes the completing one.
  - Reserve together with flush leaves only rsv_addr pending.
  - Writes need no reservation. An unreserved write updates data and leaves the bit at 0.
- rd_busy[p] = pending[rd_addr[p]], except when BYPASS=1 and a write to that nonzero address is active this cycle; then rd_busy[p]=0.
- pending_cnt is a registered population count of the pending bits, updated on the same edge as the bits. Range 0 to NUM_REGS-1; it never wraps.

## Timing
- Reset values: all registers 0, all pending bits 0, pending_cnt=0. rd_data and rd_busy therefore read 0 during reset.
- Read latency is 0 cycles (combinational from rd_addr, wr_*).
- Write latency is 1 edge. With BYPASS=0, data is visible on the cycle after wr_en.
- rsv_en asserted in cycle t gives rd_busy=1 for that register from cycle t+1. It stays 1 until the cycle in which the matching write is presented (BYPASS=1) or the cycle after it (BYPASS=0).
- Reset asserted mid-operation clears all state immediately, including in-flight reservations. The next edge after deassertion behaves as a first cycle.
- No handshake back-pressure: every write is accepted. The issue stage must not issue while rd_busy is 1.

## Structure
- Package rv32i_rf_pkg holds:
  - AW and CW helper functions;
  - a reg-address typedef;
  - constant X0 = '0.
- Sub-module rv32i_rf_scoreboard holds the pending vector, the update priority and the popcount register. The top level holds storage, write-priority muxes and bypass muxes.
- Read and write ports are built with generate loops over NUM_RD_PORTS and NUM_WR_PORTS.

## Test plan
- Reset, then write x5=0xDEADBEEF; next cycle read x5 gives 0xDEADBEEF. Write x0=0x1234, then read x0 gives 0.
- BYPASS=1: write x7=0xA5A5A5A5 and read x7 in the same cycle gives 0xA5A5A5A5. With BYPASS=0 the same stimulus returns the old value 0.
- Two write ports both write x3 (port0=0x11, port1=0x22) gives x3=0x22.
- Reserve x9 gives rd_busy=1 and pending_cnt=1 next cycle. Write x9=0x42 gives busy=0 (BYPASS=1: same cycle) and pending_cnt=0. Reserve and write x9 together keeps busy=1.
- Reserve x1, x2, x3 (pending_cnt=3), then flush with reserve x4 gives pending_cnt=1 and only x4 busy.
- Assert rst mid-sequence with 3 reservations and nonzero registers gives all rd_data=0, rd_busy=0 and pending_cnt=0 without a clock edge.
